// File: rtl/uart_seq_pkg.sv
// Shared types for the CoreUART byte sequencer.
// FSM state encoding, rx error bit positions, guard counter type.
package uart_seq_pkg;

    localparam int GCNT_W  = 3;
    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_OVF = 2;

    typedef logic [GCNT_W-1:0] gcnt_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WR_G = 3'd2,
        S_RD   = 3'd3,
        S_RD_G = 3'd4
    } state_e;

endpackage

// File: rtl/uart_core_sequencer_if.sv
// CSN/WEN/OEN byte interface of one CoreUART instance.
// master = sequencer side, slave = UART core side.
interface uart_core_sequencer_if;

    logic       UART_CSN;
    logic       UART_WEN;
    logic       UART_OEN;
    logic [7:0] UART_DATA_IN;
    logic [7:0] UART_DATA_OUT;
    logic       UART_TXRDY;
    logic       UART_RXRDY;
    logic       UART_PARITY_ERR;
    logic       UART_FRAMING_ERR;
    logic       UART_OVERFLOW;

    modport master (
        output UART_CSN,
        output UART_WEN,
        output UART_OEN,
        output UART_DATA_IN,
        input  UART_DATA_OUT,
        input  UART_TXRDY,
        input  UART_RXRDY,
        input  UART_PARITY_ERR,
        input  UART_FRAMING_ERR,
        input  UART_OVERFLOW
    );

    modport slave (
        input  UART_CSN,
        input  UART_WEN,
        input  UART_OEN,
        input  UART_DATA_IN,
        output UART_DATA_OUT,
        output UART_TXRDY,
        output UART_RXRDY,
        output UART_PARITY_ERR,
        output UART_FRAMING_ERR,
        output UART_OVERFLOW
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker; search starts one past `last`.
// The pointer register lives in the parent.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt    = '0;
        gnt_id = last;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = 2'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_core_sequencer.sv
// Sequences CoreUART strobes, round-robins TX requesters and
// drains RX bytes with error flags into a one-entry buffer.
module uart_core_sequencer
    import uart_seq_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int TX_GUARD = 2,
    parameter int RX_GUARD = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [1:0]           grant_id,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [7:0]           rx_data,
    output logic [2:0]           rx_err,
    uart_core_sequencer_if.master core
);

    localparam gcnt_t TXG = gcnt_t'(TX_GUARD);
    localparam gcnt_t RXG = gcnt_t'(RX_GUARD);
    localparam gcnt_t ONE = gcnt_t'(1);

    state_e       state_q, state_d;
    gcnt_t        cnt_q, cnt_d;
    logic         csn_q, csn_d;
    logic         wen_q, wen_d;
    logic         oen_q, oen_d;
    logic [7:0]   din_q, din_d;
    logic [1:0]   gid_q, gid_d;
    logic         rxv_q, rxv_d;
    logic [7:0]   rxd_q, rxd_d;
    logic [2:0]   rxe_q, rxe_d;

    logic               rd_go;
    logic               arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         gnt_id;
    logic [7:0]         sel;

    // RX wins the IDLE slot when the buffer is free or draining now
    assign rd_go  = core.UART_RXRDY && (!rxv_q || rx_ready);
    assign arb_en = (state_q == S_IDLE) && !rd_go && core.UART_TXRDY;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .last   (gid_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel = req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        gid_d   = gid_q;
        rxv_d   = rxv_q && !rx_ready;
        rxd_d   = rxd_q;
        rxe_d   = rxe_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_go) begin
                    state_d = S_RD;
                end else if (|gnt) begin
                    state_d = S_WR;
                    din_d   = sel;
                    gid_d   = gnt_id;
                end
            end
            S_WR: begin
                state_d = S_WR_G;
                cnt_d   = TXG;
            end
            S_RD: begin
                state_d        = S_RD_G;
                cnt_d          = RXG;
                rxv_d          = 1'b1;
                rxd_d          = core.UART_DATA_OUT;
                rxe_d[ERR_PAR] = core.UART_PARITY_ERR;
                rxe_d[ERR_FRM] = core.UART_FRAMING_ERR;
                rxe_d[ERR_OVF] = core.UART_OVERFLOW;
            end
            S_WR_G, S_RD_G: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // strobes follow the next state so they are registered
        csn_d = !((state_d == S_WR) || (state_d == S_RD));
        wen_d = (state_d != S_WR);
        oen_d = (state_d != S_RD);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            csn_q   <= 1'b1;
            wen_q   <= 1'b1;
            oen_q   <= 1'b1;
            din_q   <= '0;
            gid_q   <= 2'(NUM_REQ - 1);
            rxv_q   <= 1'b0;
            rxd_q   <= '0;
            rxe_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csn_q   <= csn_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            din_q   <= din_d;
            gid_q   <= gid_d;
            rxv_q   <= rxv_d;
            rxd_q   <= rxd_d;
            rxe_q   <= rxe_d;
        end
    end

    assign req_ready         = gnt;
    assign grant_id          = gid_q;
    assign rx_valid          = rxv_q;
    assign rx_data           = rxd_q;
    assign rx_err            = rxe_q;
    assign core.UART_CSN     = csn_q;
    assign core.UART_WEN     = wen_q;
    assign core.UART_OEN     = oen_q;
    assign core.UART_DATA_IN = din_q;

endmodule

// File: tb/tb_uart_core_sequencer.sv
// Directed bench for uart_core_sequencer with a cycle-level
// timeline model checked on every falling edge.
module tb_uart_core_sequencer;

    localparam int NR  = 2;
    localparam int TXG = 2;
    localparam int RXG = 2;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic [1:0]      grant_id;
    logic            rx_valid;
    logic            rx_ready = 1'b0;
    logic [7:0]      rx_data;
    logic [2:0]      rx_err;

    uart_core_sequencer_if u_if ();

    uart_core_sequencer #(
        .NUM_REQ  (NR),
        .TX_GUARD (TXG),
        .RX_GUARD (RXG)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .core      (u_if)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    int g_log[$];
    int g_cyc[$];
    int w_cyc[$];
    int w_dat[$];
    int r_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // Model: m_str is the strobe expected in the current cycle
    // (0 none, 1 write, 2 read); m_wait counts remaining guard cycles.
    int            m_str, m_wait, m_last, m_g;
    bit            m_rd, m_rxv;
    logic [7:0]    m_din, m_rxd;
    logic [2:0]    m_rxe;
    logic [NR-1:0] m_rr;

    always @(negedge CLK) begin
        if (!RESET_N) begin
            m_str  = 0;
            m_wait = 0;
            m_last = NR - 1;
            m_din  = '0;
            m_rxv  = 1'b0;
            m_rxd  = '0;
            m_rxe  = '0;
        end else begin
            m_rd = (m_str == 0) && (m_wait == 0) && u_if.UART_RXRDY
                   && (!m_rxv || rx_ready);
            m_g = -1;
            if (m_str == 0 && m_wait == 0 && !m_rd && u_if.UART_TXRDY)
                for (int k = 1; k <= NR; k++)
                    if (m_g < 0 && req_valid[(m_last + k) % NR])
                        m_g = (m_last + k) % NR;
            m_rr = (m_g >= 0) ? NR'(1 << m_g) : '0;

            check("csn", u_if.UART_CSN, m_str == 0);
            check("wen", u_if.UART_WEN, m_str != 1);
            check("oen", u_if.UART_OEN, m_str != 2);
            check("data_in", u_if.UART_DATA_IN, m_din);
            check("req_ready", req_ready, m_rr);
            check("grant_id", grant_id, m_last);
            check("rx_valid", rx_valid, m_rxv);
            if (m_rxv) begin
                check("rx_data", rx_data, m_rxd);
                check("rx_err", rx_err, m_rxe);
            end

            if (req_ready != '0) begin
                g_log.push_back(req_ready[1] ? 1 : 0);
                g_cyc.push_back(cyc);
            end
            if (!u_if.UART_WEN) begin
                w_cyc.push_back(cyc);
                w_dat.push_back(int'(u_if.UART_DATA_IN));
            end
            if (!u_if.UART_OEN) r_cyc.push_back(cyc);

            if (m_str == 2) begin
                m_rxv = 1'b1;
                m_rxd = u_if.UART_DATA_OUT;
                m_rxe = {u_if.UART_OVERFLOW, u_if.UART_FRAMING_ERR,
                         u_if.UART_PARITY_ERR};
            end else if (m_rxv && rx_ready) begin
                m_rxv = 1'b0;
            end

            if (m_str != 0) begin
                m_wait = (m_str == 1) ? TXG : RXG;
                m_str  = 0;
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (m_rd) begin
                m_str = 2;
            end else if (m_g >= 0) begin
                m_str  = 1;
                m_din  = req_data[8*m_g +: 8];
                m_last = m_g;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int bg, bw, br, t0;

    initial begin
        u_if.UART_DATA_OUT    = '0;
        u_if.UART_TXRDY       = 1'b0;
        u_if.UART_RXRDY       = 1'b0;
        u_if.UART_PARITY_ERR  = 1'b0;
        u_if.UART_FRAMING_ERR = 1'b0;
        u_if.UART_OVERFLOW    = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET_N = 1'b1;
        #1;
        check("rst_csn", u_if.UART_CSN, 1);
        check("rst_wen", u_if.UART_WEN, 1);
        check("rst_oen", u_if.UART_OEN, 1);
        check("rst_din", u_if.UART_DATA_IN, 0);
        check("rst_rr", req_ready, 0);
        check("rst_rxv", rx_valid, 0);
        check("rst_rxd", rx_data, 0);
        check("rst_rxe", rx_err, 0);
        check("rst_gid", grant_id, 1);
        tick();

        // T1: single requester, write spacing 2+TX_GUARD
        bg = g_log.size(); bw = w_cyc.size();
        req_data[7:0] = 8'h55;
        req_valid = 2'b01;
        u_if.UART_TXRDY = 1'b1;
        repeat (5) tick();
        req_valid = '0;
        repeat (4) tick();
        check("t1_ngrant", g_log.size() - bg, 2);
        check("t1_gid0", at(g_log, bg), 0);
        check("t1_lat", at(w_cyc, bw) - at(g_cyc, bg), 1);
        check("t1_space", at(w_cyc, bw + 1) - at(w_cyc, bw), 4);
        check("t1_data", at(w_dat, bw), 8'h55);

        // T2: both requesters; last grant was 0 so req1 leads
        bg = g_log.size(); bw = w_cyc.size();
        req_data = {8'hBB, 8'hAA};
        req_valid = 2'b11;
        repeat (13) tick();
        req_valid = '0;
        repeat (4) tick();
        check("t2_nwr", w_cyc.size() - bw, 4);
        check("t2_g0", at(g_log, bg), 1);
        check("t2_g1", at(g_log, bg + 1), 0);
        check("t2_g2", at(g_log, bg + 2), 1);
        check("t2_g3", at(g_log, bg + 3), 0);
        check("t2_d0", at(w_dat, bw), 8'hBB);
        check("t2_d1", at(w_dat, bw + 1), 8'hAA);
        check("t2_d3", at(w_dat, bw + 3), 8'hAA);
        check("t2_gid", grant_id, 0);

        // T3: read with parity error, buffer held by consumer
        br = r_cyc.size();
        u_if.UART_DATA_OUT = 8'hA3;
        u_if.UART_PARITY_ERR = 1'b1;
        u_if.UART_RXRDY = 1'b1;
        repeat (10) tick();
        check("t3_nrd", r_cyc.size() - br, 1);
        check("t3_rxv", rx_valid, 1);
        check("t3_rxd", rx_data, 8'hA3);
        check("t3_rxe", rx_err, 3'b001);

        // T5: consumer takes A3 while the next byte is pending
        u_if.UART_DATA_OUT = 8'h5C;
        u_if.UART_PARITY_ERR = 1'b0;
        u_if.UART_FRAMING_ERR = 1'b1;
        rx_ready = 1'b1;
        t0 = cyc;
        tick();
        rx_ready = 1'b0;
        u_if.UART_RXRDY = 1'b0;
        repeat (5) tick();
        check("t5_nrd", r_cyc.size() - br, 2);
        check("t5_lat", at(r_cyc, br + 1) - t0, 1);
        check("t5_rxv", rx_valid, 1);
        check("t5_rxd", rx_data, 8'h5C);
        check("t5_rxe", rx_err, 3'b010);

        // T4: RX and TX in the same IDLE cycle, read goes first
        bg = g_log.size(); bw = w_cyc.size(); br = r_cyc.size();
        rx_ready = 1'b1;
        u_if.UART_DATA_OUT = 8'h3C;
        u_if.UART_FRAMING_ERR = 1'b0;
        u_if.UART_OVERFLOW = 1'b1;
        req_data[7:0] = 8'h77;
        req_valid = 2'b01;
        u_if.UART_RXRDY = 1'b1;
        t0 = cyc;
        tick();
        u_if.UART_RXRDY = 1'b0;
        repeat (4) tick();
        req_valid = '0;
        repeat (4) tick();
        check("t4_rd_lat", at(r_cyc, br) - t0, 1);
        check("t4_rd2wr", at(w_cyc, bw) - at(r_cyc, br), 4);
        check("t4_ngrant", g_log.size() - bg, 1);
        check("t4_gid", at(g_log, bg), 0);
        check("t4_data", at(w_dat, bw), 8'h77);
        check("t4_rxd", rx_data, 8'h3C);
        check("t4_rxe", rx_err, 3'b100);
        check("t4_rxv", rx_valid, 0);

        // T6: async reset in the middle of a write
        req_data = {8'hEE, 8'h99};
        req_valid = 2'b01;
        #1;
        check("t6_rr", req_ready, 2'b01);
        tick();
        check("t6_wen", u_if.UART_WEN, 0);
        check("t6_din", u_if.UART_DATA_IN, 8'h99);
        req_valid = 2'b11;
        #2 RESET_N = 1'b0;
        #1;
        check("t6_csn", u_if.UART_CSN, 1);
        check("t6_wen_rst", u_if.UART_WEN, 1);
        check("t6_oen", u_if.UART_OEN, 1);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        bg = g_log.size(); bw = w_cyc.size();
        #1;
        check("t6_gid_rst", grant_id, 1);
        check("t6_din_rst", u_if.UART_DATA_IN, 0);
        repeat (6) tick();
        req_valid = '0;
        repeat (4) tick();
        check("t6_first", at(g_log, bg), 0);
        check("t6_second", at(g_log, bg + 1), 1);
        check("t6_data", at(w_dat, bw), 8'h99);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
